// File: rtl/dmem_lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
package dmem_lsu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LANE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } lsuState_t;

    typedef struct packed {
        logic              we;
        logic              byteOp;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } lsuReq_t;

    localparam logic [DATA_W-1:0] RDATA_RST = '0;
    localparam logic [DATA_W-1:0] BUF_RST   = '0;
    localparam logic [ADDR_W-1:0] ADDR_RST  = '0;
    localparam logic [DATA_W-1:0] WDATA_RST = '0;

    // Memory is word-organised, so the lane bits never reach it.
    function automatic logic [ADDR_W-1:0] wordAddr(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:LANE_W], LANE_W'(0)};
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane extract (zero-extended) and byte merge for sub-word accesses.
module lsu_byte_lane
    import dmem_lsu_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [LANE_W-1:0] lane,
    input  logic [DATA_W-1:0] extWord,
    input  logic [DATA_W-1:0] mergeWord,
    input  logic [BYTE_W-1:0] newByte,
    output logic [DATA_W-1:0] extByte,
    output logic [DATA_W-1:0] merged
);

    logic [LANE_W-1:0] physLane;

    // Big-endian lane k lives at bit position of little-endian lane 3-k.
    assign physLane = BIG_ENDIAN ? ~lane : lane;

    always_comb begin
        extByte = '0;
        merged  = mergeWord;
        extByte[BYTE_W-1:0]              = extWord[{physLane, 3'b000} +: BYTE_W];
        merged[{physLane, 3'b000} +: BYTE_W] = newByte;
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving a single-cycle data memory; byte stores are
// performed as read-modify-write of the containing word.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter bit BIG_ENDIAN  = 1'b0,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic              byte_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd
);

    lsuState_t         state;
    lsuReq_t           reqQ;
    logic [DATA_W-1:0] buffer;
    logic [DATA_W-1:0] loadByte;
    logic [DATA_W-1:0] mergedWord;
    logic              misaligned;

    assign misaligned = CHECK_ALIGN && !byte_op && (addr[LANE_W-1:0] != '0);

    lsu_byte_lane #(.BIG_ENDIAN(BIG_ENDIAN)) uLane (
        .lane      (reqQ.addr[LANE_W-1:0]),
        .extWord   (mem_rd),
        .mergeWord (buffer),
        .newByte   (reqQ.wdata[BYTE_W-1:0]),
        .extByte   (loadByte),
        .merged    (mergedWord)
    );

    // Sequencer: request latch, read buffer and completion outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            reqQ   <= '{we: 1'b0, byteOp: 1'b0, addr: ADDR_RST, wdata: WDATA_RST};
            buffer <= BUF_RST;
            busy   <= 1'b0;
            done   <= 1'b0;
            rdata  <= RDATA_RST;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        reqQ <= '{we: we, byteOp: byte_op, addr: addr, wdata: wdata};
                        err  <= misaligned;
                        busy <= 1'b1;
                        if (misaligned) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (!we || byte_op) begin
                            state <= RD;
                        end else begin
                            state <= WR;
                        end
                    end
                end
                RD: begin
                    buffer <= mem_rd;
                    if (reqQ.we) begin
                        state <= WR;
                    end else begin
                        // The buffer is loading this same edge, so take the lane from mem_rd.
                        state <= DONE;
                        done  <= 1'b1;
                        rdata <= reqQ.byteOp ? loadByte : mem_rd;
                    end
                end
                WR: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Memory-side strobes are pure state decodes so reset silences them at once.
    always_comb begin
        mem_a  = ADDR_RST;
        mem_wd = '0;
        mem_we = 1'b0;
        case (state)
            RD: begin
                mem_a = wordAddr(reqQ.addr);
            end
            WR: begin
                mem_a  = wordAddr(reqQ.addr);
                mem_we = 1'b1;
                mem_wd = reqQ.byteOp ? mergedWord : reqQ.wdata;
            end
            default: begin
                mem_a  = ADDR_RST;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: little- and big-endian instances share stimulus and
// are checked against a word-array reference model.
`timescale 1ns/1ps
module tb_dmem_lsu;

    typedef struct {
        int          lat;
        int          weCnt;
        logic [31:0] weAddr;
        logic [31:0] weData;
    } obs_t;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        req     = 1'b0;
    logic        we      = 1'b0;
    logic        byteOp  = 1'b0;
    logic [31:0] addr    = '0;
    logic [31:0] wdata   = '0;

    logic        busyA, doneA, errA, memWeA;
    logic [31:0] rdataA, memAA, memWdA, memRdA;
    logic        busyB, doneB, errB, memWeB;
    logic [31:0] rdataB, memAB, memWdB, memRdB;

    bit   [31:0] memA [64];
    bit   [31:0] memB [64];
    bit   [31:0] refA [64];
    bit   [31:0] refB [64];
    logic [31:0] expRdA = '0;
    logic [31:0] expRdB = '0;
    logic        expErr = 1'b0;

    int checkCnt   = 0;
    int passCnt    = 0;
    int quietViolA = 0;
    int quietViolB = 0;

    always #5 clk = ~clk;

    dmem_lsu #(.BIG_ENDIAN(1'b0), .CHECK_ALIGN(1'b1)) dutA (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we), .byte_op(byteOp),
        .addr(addr), .wdata(wdata), .busy(busyA), .done(doneA), .rdata(rdataA),
        .err(errA), .mem_a(memAA), .mem_wd(memWdA), .mem_we(memWeA), .mem_rd(memRdA)
    );

    dmem_lsu #(.BIG_ENDIAN(1'b1), .CHECK_ALIGN(1'b1)) dutB (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we), .byte_op(byteOp),
        .addr(addr), .wdata(wdata), .busy(busyB), .done(doneB), .rdata(rdataB),
        .err(errB), .mem_a(memAB), .mem_wd(memWdB), .mem_we(memWeB), .mem_rd(memRdB)
    );

    // Single-cycle memories: combinational read, write on the clock edge.
    assign memRdA = memA[memAA[7:2]];
    assign memRdB = memB[memAB[7:2]];

    always @(posedge clk) begin
        if (memWeA) memA[memAA[7:2]] <= memWdA;
        if (memWeB) memB[memAB[7:2]] <= memWdB;
    end

    // Outside an active access the memory port must be silent.
    always @(negedge clk) begin
        if (reset_n) begin
            if ((!busyA || doneA) && (memWeA || memAA != 0 || memWdA != 0)) quietViolA++;
            if ((!busyB || doneB) && (memWeB || memAB != 0 || memWdB != 0)) quietViolB++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic int laneShift(input logic [1:0] lane, input bit be);
        return be ? 8 * (3 - int'(lane)) : 8 * int'(lane);
    endfunction

    // Reference model: what one accepted request should do.
    task automatic modelTxn(input logic w, input logic bo, input logic [31:0] a,
                            input logic [31:0] d, output int lat, output bit wr,
                            output logic [31:0] wAddr, output logic [31:0] wDataA,
                            output logic [31:0] wDataB);
        int idx = int'(a[7:2]);
        int shA = laneShift(a[1:0], 1'b0);
        int shB = laneShift(a[1:0], 1'b1);
        wr     = 1'b0;
        wAddr  = a & 32'hFFFF_FFFC;
        wDataA = '0;
        wDataB = '0;
        if (!bo && a[1:0] != 2'b00) begin
            lat    = 1;
            expErr = 1'b1;
        end else begin
            expErr = 1'b0;
            if (!w) begin
                lat    = 2;
                expRdA = bo ? ((refA[idx] >> shA) & 32'hFF) : refA[idx];
                expRdB = bo ? ((refB[idx] >> shB) & 32'hFF) : refB[idx];
            end else if (!bo) begin
                lat       = 2;
                wr        = 1'b1;
                refA[idx] = d;
                refB[idx] = d;
                wDataA    = d;
                wDataB    = d;
            end else begin
                lat       = 3;
                wr        = 1'b1;
                refA[idx] = (refA[idx] & ~(32'hFF << shA)) | ({24'h0, d[7:0]} << shA);
                refB[idx] = (refB[idx] & ~(32'hFF << shB)) | ({24'h0, d[7:0]} << shB);
                wDataA    = refA[idx];
                wDataB    = refB[idx];
            end
        end
    endtask

    // Issue one single-cycle request and observe both units until done.
    task automatic runTxn(input logic w, input logic bo, input logic [31:0] a,
                          input logic [31:0] d, output obs_t oA, output obs_t oB);
        bit gotA = 1'b0;
        bit gotB = 1'b0;
        oA = '{lat: -1, weCnt: 0, weAddr: '0, weData: '0};
        oB = '{lat: -1, weCnt: 0, weAddr: '0, weData: '0};
        @(negedge clk);
        req = 1'b1; we = w; byteOp = bo; addr = a; wdata = d;
        for (int c = 1; c <= 8 && !(gotA && gotB); c++) begin
            @(negedge clk);
            if (c == 1) req = 1'b0;
            if (memWeA) begin oA.weCnt++; oA.weAddr = memAA; oA.weData = memWdA; end
            if (memWeB) begin oB.weCnt++; oB.weAddr = memAB; oB.weData = memWdB; end
            if (doneA && !gotA) begin gotA = 1'b1; oA.lat = c; end
            if (doneB && !gotB) begin gotB = 1'b1; oB.lat = c; end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checkCnt++; if ({busyA, doneA, errA, memWeA, busyB, doneB, errB, memWeB} !== 8'h00)
            $display("FAIL reset_flags: got %b want 00000000", {busyA, doneA, errA, memWeA, busyB, doneB, errB, memWeB}); else passCnt++;
        reset_n = 1'b1;
        @(negedge clk);
        checkCnt++; if (rdataA !== 32'h0 || rdataB !== 32'h0)
            $display("FAIL reset_rdata: got %h/%h want 0", rdataA, rdataB); else passCnt++;
        checkCnt++; if (memAA !== 32'h0 || memWdA !== 32'h0 || memAB !== 32'h0 || memWdB !== 32'h0)
            $display("FAIL reset_mem_port: got a=%h wd=%h want 0", memAA, memWdA); else passCnt++;
    endtask

    task automatic test_word_store_load();
        obs_t oA, oB; int lat; bit wr; logic [31:0] wa, wda, wdb;
        modelTxn(1'b1, 1'b0, 32'h8, 32'hDEADBEEF, lat, wr, wa, wda, wdb);
        runTxn(1'b1, 1'b0, 32'h8, 32'hDEADBEEF, oA, oB);
        checkCnt++; if (oA.lat !== 2 || oB.lat !== 2)
            $display("FAIL wstore_latency: got %0d/%0d want 2", oA.lat, oB.lat); else passCnt++;
        checkCnt++; if (oA.weCnt !== 1 || oA.weAddr !== 32'h8 || oA.weData !== 32'hDEADBEEF)
            $display("FAIL wstore_write: got cnt=%0d a=%h d=%h want 1 00000008 deadbeef", oA.weCnt, oA.weAddr, oA.weData); else passCnt++;
        checkCnt++; if (rdataA !== 32'h0 || rdataB !== 32'h0)
            $display("FAIL wstore_rdata_held: got %h/%h want 0", rdataA, rdataB); else passCnt++;
        modelTxn(1'b0, 1'b0, 32'h8, 32'h0, lat, wr, wa, wda, wdb);
        runTxn(1'b0, 1'b0, 32'h8, 32'h0, oA, oB);
        checkCnt++; if (oA.lat !== 2 || rdataA !== 32'hDEADBEEF || rdataB !== 32'hDEADBEEF || errA !== 1'b0)
            $display("FAIL wload: got lat=%0d rdata=%h/%h err=%b want 2 deadbeef 0", oA.lat, rdataA, rdataB, errA); else passCnt++;
    endtask

    task automatic test_byte_store();
        obs_t oA, oB; int lat; bit wr; logic [31:0] wa, wda, wdb;
        modelTxn(1'b1, 1'b1, 32'h9, 32'h0000_00AA, lat, wr, wa, wda, wdb);
        runTxn(1'b1, 1'b1, 32'h9, 32'h0000_00AA, oA, oB);
        checkCnt++; if (oA.lat !== 3 || oB.lat !== 3)
            $display("FAIL bstore_latency: got %0d/%0d want 3", oA.lat, oB.lat); else passCnt++;
        checkCnt++; if (oA.weCnt !== 1 || oA.weData !== 32'hDEADAAEF)
            $display("FAIL bstore_merge_le: got cnt=%0d d=%h want 1 deadaaef", oA.weCnt, oA.weData); else passCnt++;
        checkCnt++; if (oB.weCnt !== 1 || oB.weData !== 32'hDEAABEEF)
            $display("FAIL bstore_merge_be: got cnt=%0d d=%h want 1 deaabeef", oB.weCnt, oB.weData); else passCnt++;
        modelTxn(1'b0, 1'b0, 32'h8, 32'h0, lat, wr, wa, wda, wdb);
        runTxn(1'b0, 1'b0, 32'h8, 32'h0, oA, oB);
        checkCnt++; if (rdataA !== 32'hDEADAAEF || rdataB !== 32'hDEAABEEF)
            $display("FAIL bstore_readback: got %h/%h want deadaaef/deaabeef", rdataA, rdataB); else passCnt++;
    endtask

    task automatic test_byte_load();
        obs_t oA, oB; int lat; bit wr; logic [31:0] wa, wda, wdb;
        modelTxn(1'b0, 1'b1, 32'hB, 32'h0, lat, wr, wa, wda, wdb);
        runTxn(1'b0, 1'b1, 32'hB, 32'h0, oA, oB);
        checkCnt++; if (oA.lat !== 2 || rdataA !== 32'h0000_00DE)
            $display("FAIL bload_le: got lat=%0d rdata=%h want 2 000000de", oA.lat, rdataA); else passCnt++;
        checkCnt++; if (oB.lat !== 2 || rdataB !== 32'h0000_00EF)
            $display("FAIL bload_be: got lat=%0d rdata=%h want 2 000000ef", oB.lat, rdataB); else passCnt++;
    endtask

    task automatic test_misaligned();
        obs_t oA, oB; int lat; bit wr; logic [31:0] wa, wda, wdb;
        modelTxn(1'b0, 1'b0, 32'h6, 32'h0, lat, wr, wa, wda, wdb);
        runTxn(1'b0, 1'b0, 32'h6, 32'h0, oA, oB);
        checkCnt++; if (oA.lat !== 1 || oB.lat !== 1 || errA !== 1'b1 || errB !== 1'b1)
            $display("FAIL misalign_err: got lat=%0d/%0d err=%b/%b want 1 1", oA.lat, oB.lat, errA, errB); else passCnt++;
        checkCnt++; if (oA.weCnt !== 0 || rdataA !== 32'h0000_00DE || rdataB !== 32'h0000_00EF)
            $display("FAIL misalign_side_effects: got we=%0d rdata=%h/%h want 0 de/ef", oA.weCnt, rdataA, rdataB); else passCnt++;
        modelTxn(1'b0, 1'b1, 32'h8, 32'h0, lat, wr, wa, wda, wdb);
        runTxn(1'b0, 1'b1, 32'h8, 32'h0, oA, oB);
        checkCnt++; if (errA !== 1'b0 || errB !== 1'b0 || rdataA !== 32'h0000_00EF || rdataB !== 32'h0000_00DE)
            $display("FAIL misalign_clear: got err=%b/%b rdata=%h/%h want 0 ef/de", errA, errB, rdataA, rdataB); else passCnt++;
    endtask

    task automatic test_hold_req();
        logic [4:0] doneVecA = '0, doneVecB = '0, busyVecA = '0, busyVecB = '0;
        int lat; bit wr; logic [31:0] wa, wda, wdb;
        modelTxn(1'b0, 1'b0, 32'h8, 32'h0, lat, wr, wa, wda, wdb);
        @(negedge clk);
        req = 1'b1; we = 1'b0; byteOp = 1'b0; addr = 32'h8; wdata = 32'h0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            doneVecA[c-1] = doneA; doneVecB[c-1] = doneB;
            busyVecA[c-1] = busyA; busyVecB[c-1] = busyB;
            if (c == 4) req = 1'b0;
        end
        modelTxn(1'b0, 1'b0, 32'h8, 32'h0, lat, wr, wa, wda, wdb);
        checkCnt++; if (doneVecA !== 5'b10010 || doneVecB !== 5'b10010)
            $display("FAIL hold_done_pattern: got %b/%b want 10010", doneVecA, doneVecB); else passCnt++;
        checkCnt++; if (busyVecA !== 5'b11011 || busyVecB !== 5'b11011)
            $display("FAIL hold_busy_pattern: got %b/%b want 11011", busyVecA, busyVecB); else passCnt++;
        checkCnt++; if (rdataA !== expRdA || rdataB !== expRdB)
            $display("FAIL hold_rdata: got %h/%h want %h/%h", rdataA, rdataB, expRdA, expRdB); else passCnt++;
    endtask

    task automatic test_random();
        obs_t oA, oB; int lat; bit wr; logic [31:0] wa, wda, wdb;
        logic w, bo; logic [31:0] a, d;
        for (int i = 0; i < 60; i++) begin
            w  = 1'($urandom_range(0, 1));
            bo = 1'($urandom_range(0, 1));
            a  = $urandom;
            d  = $urandom;
            if (!bo && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            modelTxn(w, bo, a, d, lat, wr, wa, wda, wdb);
            runTxn(w, bo, a, d, oA, oB);
            checkCnt++; if (oA.lat !== lat || oB.lat !== lat)
                $display("FAIL rand_latency[%0d]: got %0d/%0d want %0d", i, oA.lat, oB.lat, lat); else passCnt++;
            checkCnt++; if (rdataA !== expRdA || rdataB !== expRdB)
                $display("FAIL rand_rdata[%0d]: got %h/%h want %h/%h", i, rdataA, rdataB, expRdA, expRdB); else passCnt++;
            checkCnt++; if (errA !== expErr || errB !== expErr)
                $display("FAIL rand_err[%0d]: got %b/%b want %b", i, errA, errB, expErr); else passCnt++;
            checkCnt++; if (oA.weCnt !== int'(wr) || oB.weCnt !== int'(wr))
                $display("FAIL rand_we_count[%0d]: got %0d/%0d want %0d", i, oA.weCnt, oB.weCnt, int'(wr)); else passCnt++;
            if (wr) begin
                checkCnt++; if (oA.weAddr !== wa || oA.weData !== wda || oB.weAddr !== wa || oB.weData !== wdb)
                    $display("FAIL rand_write[%0d]: got %h:%h/%h:%h want %h:%h/%h", i, oA.weAddr, oA.weData, oB.weAddr, oB.weData, wa, wda, wdb); else passCnt++;
            end
        end
    endtask

    task automatic test_reset_mid_rmw();
        obs_t oA, oB; int lat; bit wr; logic [31:0] wa, wda, wdb;
        modelTxn(1'b1, 1'b0, 32'h10, 32'h1234_5678, lat, wr, wa, wda, wdb);
        runTxn(1'b1, 1'b0, 32'h10, 32'h1234_5678, oA, oB);
        @(negedge clk);
        req = 1'b1; we = 1'b1; byteOp = 1'b1; addr = 32'h10; wdata = 32'h0000_0055;
        @(negedge clk);
        req = 1'b0;
        checkCnt++; if (busyA !== 1'b1 || memWeA !== 1'b0 || memAA !== 32'h10)
            $display("FAIL rmw_in_read: got busy=%b we=%b a=%h want 1 0 00000010", busyA, memWeA, memAA); else passCnt++;
        reset_n = 1'b0;
        #1;
        checkCnt++; if ({busyA, doneA, memWeA, busyB, doneB, memWeB} !== 6'b0 || memAA !== 32'h0 || memWdA !== 32'h0)
            $display("FAIL rmw_reset_drop: got flags=%b a=%h wd=%h want 0", {busyA, doneA, memWeA, busyB, doneB, memWeB}, memAA, memWdA); else passCnt++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        expRdA = '0; expRdB = '0; expErr = 1'b0;
        @(negedge clk);
        checkCnt++; if (memA[4] !== refA[4] || memB[4] !== refB[4])
            $display("FAIL rmw_mem_intact: got %h/%h want %h/%h", memA[4], memB[4], refA[4], refB[4]); else passCnt++;
        checkCnt++; if (rdataA !== 32'h0 || errA !== 1'b0 || rdataB !== 32'h0)
            $display("FAIL rmw_reset_outputs: got rdata=%h err=%b want 0 0", rdataA, errA); else passCnt++;
        modelTxn(1'b0, 1'b0, 32'h10, 32'h0, lat, wr, wa, wda, wdb);
        runTxn(1'b0, 1'b0, 32'h10, 32'h0, oA, oB);
        checkCnt++; if (rdataA !== 32'h1234_5678 || rdataB !== 32'h1234_5678)
            $display("FAIL rmw_readback: got %h/%h want 12345678", rdataA, rdataB); else passCnt++;
    endtask

    task automatic test_quiet_port();
        checkCnt++; if (quietViolA !== 0 || quietViolB !== 0)
            $display("FAIL quiet_port: got %0d/%0d idle-cycle memory activity want 0", quietViolA, quietViolB); else passCnt++;
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_byte_store();
        test_byte_load();
        test_misaligned();
        test_hold_req();
        test_random();
        test_reset_mid_rmw();
        test_quiet_port();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit that acts as the initiator toward the single-cycle data memory. The memory reads combinationally and writes on the clock edge. The unit accepts one word or byte request at a time from the processor datapath and sequences the memory-side address, write data and write enable. Byte stores become read-modify-write, because the memory only writes whole words. Byte loads return the addressed byte zero-extended.

Parameters:
BIG_ENDIAN, 0, byte lane order. 0 means addr[1:0]=0 selects bits[7:0]. 1 means addr[1:0]=0 selects bits[31:24].
CHECK_ALIGN, 1, when 1 a word access with addr[1:0]!=0 is rejected with err. When 0, addr[1:0] is ignored for word accesses.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous reset, active-low
req  input  1  request strobe, sampled only in IDLE
we  input  1  1=store, 0=load; sampled with req
byte_op  input  1  1=byte access, 0=word access; sampled with req
addr  input  32  byte address; sampled with req
wdata  input  32  store data; byte stores use wdata[7:0]; sampled with req
busy  output  1  high in every non-IDLE state
done  output  1  one-cycle completion pulse
rdata  output  32  load result, valid while done=1, held until next done
err  output  1  misaligned word access flag, valid with done
mem_a  output  32  memory address, word-aligned (addr[1:0] forced 0)
mem_wd  output  32  memory write data
mem_we  output  1  memory write enable
mem_rd  input  32  memory combinational read data

Behaviour:
- State machine states and transitions:
  - IDLE: on req=1, latch we, byte_op, addr, wdata.
    - Misaligned word access with CHECK_ALIGN=1 -> DONE with err.
    - Load, or byte store -> RD.
    - Word store -> WR.
  - RD: mem_a = latched word address; capture mem_rd into buffer at the edge.
    - Load -> DONE.
    - Byte store -> WR.
  - WR: mem_we=1. mem_wd = wdata for a word store, or buffer with the addressed lane replaced by wdata[7:0] for a byte store. -> DONE.
  - DONE: done=1. rdata updated at entry: word = buffer; byte = addressed lane of buffer, zero-extended. -> IDLE unconditionally.
- Latency, counting from the req-sampling edge to the done cycle:
  - word load: 2 cycles
  - word store: 2 cycles
  - byte load: 2 cycles
  - byte store: 3 cycles
  - error: 1 cycle
- mem_we is decoded from state (WR only) and is never high in any other state.
- mem_a = 0 and mem_wd = 0 in IDLE and DONE.
- req is ignored while busy=1, including during DONE. The requester must deassert req in the done cycle, or the request is re-accepted in the following IDLE.
- A store leaves rdata unchanged. err clears on the next accepted request.
- Reset (reset_n low, at any time, including mid read-modify-write):
  - state -> IDLE immediately.
  - busy=0, done=0, err=0, rdata=0, mem_we=0, mem_a=0, mem_wd=0, buffer=0.
  - A byte store interrupted in RD never writes memory.
- Address wrap: addr is passed through; the memory's own index truncation handles wrap. No bound checking is done here.

Decomposition:
- Shared package (dmem_lsu_pkg) holds:
  - state encoding constants: IDLE=2'd0, RD=2'd1, WR=2'd2, DONE=2'd3
  - lane-select width
  - reset value constants
- One combinational sub-module, lsu_byte_lane, handles:
  - byte extract, zero-extended
  - byte merge (insert wdata[7:0] into a word at lane addr[1:0])
  - the BIG_ENDIAN lane order

Test Plan:
- Word store then load, each with a single-cycle req: store 0xDEADBEEF to 0x8 -> done 2 cycles later with mem_we high one cycle at mem_a=0x8. Load from 0x8 -> rdata=0xDEADBEEF, err=0.
- Byte store 0xAA to 0x9 with word 0x8 = 0xDEADBEEF, BIG_ENDIAN=0 -> RD, WR, DONE. mem_wd=0xDEADAAEF in WR; done 3 cycles after req; later word load of 0x8 returns 0xDEADAAEF.
- Byte load from 0xB, word 0x8 = 0xDEADAAEF -> rdata=0x000000DE. Repeat with BIG_ENDIAN=1 -> 0x000000EF.
- Word load at 0x6, CHECK_ALIGN=1 -> done 1 cycle after req, err=1, mem_we never asserted, rdata unchanged. The next valid request clears err.
- Byte store to 0x10 with reset_n pulled low during RD -> busy/done/mem_we drop immediately. Memory word 0x10 is unchanged on readback after reset release.
- req held high through an entire word load -> accepted once; the DONE-cycle req is ignored; a second transaction starts only from the following IDLE.
